// File: rtl/bat_pkg.sv
// Shared definitions for the program loader: FSM states, frame byte layout
// and the RAM write-direction encoding.
package bat_pkg;

  localparam int BAT_ADDR_W = 16;
  localparam int BAT_DATA_W = 16;

  // EXT_RAM_RW level that selects a write cycle
  localparam logic RW_WRITE = 1'b1;

  // Byte offsets inside a frame; data words start at POS_DATA, CSUM follows them
  localparam int POS_ADDR_HI = 0;
  localparam int POS_ADDR_LO = 1;
  localparam int POS_CNT_HI  = 2;
  localparam int POS_CNT_LO  = 3;
  localparam int POS_DATA    = 4;

  typedef enum logic [3:0] {
    S_HDR_A1  = 4'd0,
    S_HDR_A0  = 4'd1,
    S_HDR_C1  = 4'd2,
    S_HDR_C0  = 4'd3,
    S_D_HI    = 4'd4,
    S_D_LO    = 4'd5,
    S_WRITE   = 4'd6,
    S_CSUM    = 4'd7,
    S_RELEASE = 4'd8,
    S_RUN     = 4'd9,
    S_ERROR   = 4'd10
  } state_t;

  // States in which a byte may be taken from the input stream
  function automatic logic takes_byte(input state_t s);
    case (s)
      S_HDR_A1, S_HDR_A0, S_HDR_C1, S_HDR_C0,
      S_D_HI, S_D_LO, S_CSUM, S_ERROR: takes_byte = 1'b1;
      default:                         takes_byte = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bat_loader.sv
// Program loader: halts the CPU, writes a framed big-endian word stream into
// RAM, verifies the mod-256 checksum, then resets and releases the CPU.
//
// Input handshake: a byte transfers on a rising edge where i_in_valid and
// o_in_ready are both high; o_in_ready depends only on the state register.
module bat_loader
  import bat_pkg::*;
#(
  parameter int ADDR_W = BAT_ADDR_W,
  parameter int DATA_W = BAT_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_load_req,
  output logic              o_halt,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_ext_ram_en,
  output logic              o_ext_ram_rw,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_bus_oe,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output state_t            o_state
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_cnt;
  logic [7:0]          r_hi;
  logic [DATA_W-1:0]   r_data;
  logic [7:0]          r_sum;

  state_t      w_next;
  logic        w_in_ready;
  logic        w_accept;
  logic [15:0] w_word;
  logic [7:0]  w_sum_next;
  logic        w_halt;
  logic        w_ram_en;
  logic        w_ram_rw;
  logic        w_bus_oe;
  logic        w_cpu_rst;
  logic        w_busy;
  logic        w_done;
  logic        w_err;

  assign w_in_ready = takes_byte(r_state);
  assign w_accept   = i_in_valid & w_in_ready;
  assign w_word     = {r_hi, i_in_data};
  assign w_sum_next = r_sum + i_in_data;

  always_comb begin
    w_next    = r_state;
    w_halt    = 1'b1;
    w_ram_en  = 1'b0;
    w_ram_rw  = 1'b0;
    w_bus_oe  = 1'b0;
    w_cpu_rst = 1'b0;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      S_HDR_A1: if (w_accept) w_next = S_HDR_A0;
      S_HDR_A0: if (w_accept) w_next = S_HDR_C1;
      S_HDR_C1: if (w_accept) w_next = S_HDR_C0;
      S_HDR_C0: if (w_accept) w_next = (w_word == 16'd0) ? S_CSUM : S_D_HI;
      S_D_HI:   if (w_accept) w_next = S_D_LO;
      S_D_LO:   if (w_accept) w_next = S_WRITE;
      S_WRITE: begin
        w_ram_en = 1'b1;
        w_ram_rw = RW_WRITE;
        w_bus_oe = 1'b1;
        // r_cnt is at least 1 here; this is the last word when it is exactly 1
        w_next   = (r_cnt == 16'd1) ? S_CSUM : S_D_HI;
      end
      S_CSUM:   if (w_accept) w_next = (w_sum_next == 8'd0) ? S_RELEASE : S_ERROR;
      S_RELEASE: begin
        w_cpu_rst = 1'b1;
        w_next    = S_RUN;
      end
      S_RUN: begin
        w_halt = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b1;
        if (i_load_req) w_next = S_HDR_A1;
      end
      S_ERROR: begin
        w_busy = 1'b0;
        w_err  = 1'b1;
        if (i_load_req) w_next = S_HDR_A1;
      end
      default: w_next = S_HDR_A1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_HDR_A1;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_data  <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_next;

      // Entering HDR_A1 starts a fresh frame; bytes swallowed in ERROR never count
      if (w_next == S_HDR_A1 && r_state != S_HDR_A1) begin
        r_sum <= '0;
      end else if (w_accept && r_state != S_ERROR) begin
        r_sum <= w_sum_next;
      end

      case (r_state)
        S_HDR_A1, S_HDR_C1, S_D_HI: if (w_accept) r_hi <= i_in_data;
        S_HDR_A0: if (w_accept) r_addr <= ADDR_W'(w_word);
        S_HDR_C0: if (w_accept) r_cnt  <= w_word;
        S_D_LO:   if (w_accept) r_data <= DATA_W'(w_word);
        S_WRITE: begin
          r_addr <= r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_halt       = w_halt;
  assign o_address    = r_addr;
  assign o_ext_ram_en = w_ram_en;
  assign o_ext_ram_rw = w_ram_rw;
  assign o_bus_data   = r_data;
  assign o_bus_oe     = w_bus_oe;
  assign o_cpu_rst    = w_cpu_rst;
  assign o_busy       = w_busy;
  assign o_done       = w_done;
  assign o_err        = w_err;
  assign o_state      = r_state;

endmodule
